// File: rtl/csr_bank_mc.sv
// Multi-channel CSR bank: global control, double-buffered per-channel snapshot
// and alignment configuration, sticky per-channel done status with level irq.
module csr_bank_mc #(
  parameter int          NUM_CH     = 4,
  parameter int          ADDR_W     = 8,
  parameter int          DATA_W     = 32,
  parameter int          LOCK_N_DEF = 16,
  parameter logic [31:0] VERSION    = 32'h0002_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     csr_wr_en,
  input  logic                     csr_rd_en,
  input  logic [ADDR_W-1:0]        csr_addr,
  input  logic [DATA_W-1:0]        csr_wdata,
  output logic [DATA_W-1:0]        csr_rdata,
  output logic                     csr_rvalid,
  input  logic [NUM_CH-1:0]        ch_busy,
  input  logic [NUM_CH-1:0]        snapshot_done,
  output logic [NUM_CH-1:0]        stream_enable,
  output logic [NUM_CH*DATA_W-1:0] snap_len,
  output logic [NUM_CH*8-1:0]      align_lock_n,
  output logic [NUM_CH-1:0]        align_deassert_on_err,
  output logic                     irq
);

  localparam int         BLK_W    = ADDR_W - 4;
  localparam logic [7:0] LOCK_DEF = 8'(LOCK_N_DEF);

  // Word offsets within the global block and within each channel block.
  localparam logic [1:0] W_CTRL     = 2'd0;
  localparam logic [1:0] W_STATUS   = 2'd1;
  localparam logic [1:0] W_IRQ_EN   = 2'd2;
  localparam logic [1:0] W_SNAP_LEN = 2'd0;
  localparam logic [1:0] W_ALIGN    = 2'd1;
  localparam logic [1:0] W_CH_EN    = 2'd2;

  typedef struct packed {
    logic       deassert_on_err;
    logic [7:0] lock_n;
  } align_cfg_t;

  localparam align_cfg_t CFG_RST = '{deassert_on_err: 1'b1, lock_n: LOCK_DEF};

  function automatic align_cfg_t commit_cfg(input align_cfg_t s);
    align_cfg_t r;
    r = s;
    if (s.lock_n == 8'd0) r.lock_n = LOCK_DEF;
    return r;
  endfunction

  // Global state
  logic              global_en;
  logic              commit_pending;
  logic [NUM_CH-1:0] status;
  logic [NUM_CH-1:0] irq_en;
  logic [NUM_CH-1:0] done_q;
  logic [NUM_CH-1:0] ch_en;

  // Per-channel shadow and active configuration
  logic [DATA_W-1:0] shd_len [NUM_CH];
  logic [DATA_W-1:0] act_len [NUM_CH];
  align_cfg_t        shd_cfg [NUM_CH];
  align_cfg_t        act_cfg [NUM_CH];

  // Address decode: block 0 is global, block 1+c is channel c.
  logic [BLK_W-1:0] blk;
  logic [BLK_W-1:0] ch_sel;
  logic [1:0]       word;
  logic             glb_hit;
  logic             ch_hit;
  logic             addr_lsb_unused;

  assign blk             = csr_addr[ADDR_W-1:4];
  assign word            = csr_addr[3:2];
  assign glb_hit         = (blk == '0);
  assign ch_sel          = blk - BLK_W'(1);
  assign ch_hit          = !glb_hit && (ch_sel < BLK_W'(NUM_CH));
  assign addr_lsb_unused = ^csr_addr[1:0];

  logic              wr_ctrl;
  logic              wr_status;
  logic              wr_irq_en;
  logic [NUM_CH-1:0] wr_len;
  logic [NUM_CH-1:0] wr_cfg;
  logic [NUM_CH-1:0] wr_ch_en;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    wr_ctrl   = csr_wr_en && glb_hit && (word == W_CTRL);
    wr_status = csr_wr_en && glb_hit && (word == W_STATUS);
    wr_irq_en = csr_wr_en && glb_hit && (word == W_IRQ_EN);
    wr_len    = '0;
    wr_cfg    = '0;
    wr_ch_en  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (csr_wr_en && ch_hit && (ch_sel == BLK_W'(c))) begin
        wr_len[c]   = (word == W_SNAP_LEN);
        wr_cfg[c]   = (word == W_ALIGN);
        wr_ch_en[c] = (word == W_CH_EN);
      end
    end
  end

  logic              commit_fire;
  logic [NUM_CH-1:0] done_rise;
  logic [NUM_CH-1:0] status_clr;

  assign commit_fire = commit_pending && (ch_busy == '0);
  assign done_rise   = snapshot_done & ~done_q;
  assign status_clr  = wr_status ? csr_wdata[NUM_CH-1:0] : '0;

  // NOTE: all sequential state uses non-blocking assignment, so every flop
  // samples pre-edge values; a same-cycle read therefore sees the old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      global_en      <= 1'b0;
      commit_pending <= 1'b0;
      irq_en         <= '0;
      status         <= '0;
      done_q         <= '0;
      ch_en          <= '0;
      irq            <= 1'b0;
    end else begin
      if (wr_ctrl) global_en <= csr_wdata[0];
      // A request arriving while one is pending, or in the commit cycle, adds nothing.
      if (commit_fire)                  commit_pending <= 1'b0;
      else if (wr_ctrl && csr_wdata[1]) commit_pending <= 1'b1;
      if (wr_irq_en) irq_en <= csr_wdata[NUM_CH-1:0];
      done_q <= snapshot_done;
      status <= (status & ~status_clr) | done_rise;
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ch_en[c]) ch_en[c] <= csr_wdata[0];
      end
      irq <= |(status & irq_en);
    end
  end

  // NOTE: these arrays are small register files built from flops, so they are
  // reset like any other state; a RAM-backed array would not be.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        shd_len[c] <= '0;
        act_len[c] <= '0;
        shd_cfg[c] <= CFG_RST;
        act_cfg[c] <= CFG_RST;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_len[c]) shd_len[c] <= csr_wdata;
        if (wr_cfg[c]) shd_cfg[c] <= align_cfg_t'(csr_wdata[8:0]);
        if (commit_fire) begin
          act_len[c] <= shd_len[c];
          act_cfg[c] <= commit_cfg(shd_cfg[c]);
        end
      end
    end
  end

  logic [DATA_W-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (glb_hit) begin
      case (word)
        W_CTRL:   rd_mux[1:0]        = {commit_pending, global_en};
        W_STATUS: rd_mux[NUM_CH-1:0] = status;
        W_IRQ_EN: rd_mux[NUM_CH-1:0] = irq_en;
        default:  rd_mux             = DATA_W'(VERSION);
      endcase
    end else if (ch_hit) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_sel == BLK_W'(c)) begin
          case (word)
            W_SNAP_LEN: rd_mux = shd_len[c];
            W_ALIGN:    rd_mux = DATA_W'(shd_cfg[c]);
            W_CH_EN:    rd_mux = DATA_W'(ch_en[c]);
            default:    rd_mux = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_rdata  <= '0;
      csr_rvalid <= 1'b0;
    end else begin
      csr_rvalid <= csr_rd_en;
      if (csr_rd_en) csr_rdata <= rd_mux;
    end
  end

  assign stream_enable = {NUM_CH{global_en}} & ch_en;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign snap_len[c*DATA_W +: DATA_W]  = act_len[c];
    assign align_lock_n[c*8 +: 8]        = act_cfg[c].lock_n;
    assign align_deassert_on_err[c]      = act_cfg[c].deassert_on_err;
  end

endmodule

// File: doc/csr_bank_mc.md
Name: csr_bank_mc

Overview:
- Multi-channel successor of the single-channel CSR block. Holds global control, per-channel snapshot and alignment configuration, and sticky per-channel done status with an interrupt output.
- Per-channel configuration is double-buffered: CPU writes go to shadow registers, and active registers update only on a commit, and only while no channel is busy.
- Sits between the TB/CPU CSR bus and the NUM_CH capture/alignment channels.

Parameters:
- NUM_CH, 4, number of channels (1..8)
- ADDR_W, 8, byte-address width; must satisfy 2^ADDR_W > 0x10 + 0x10*NUM_CH
- DATA_W, 32, CSR data width (>= 16)
- LOCK_N_DEF, 16, lock count applied when a committed lock_n field is 0
- VERSION, 32'h0002_0000, value of the read-only VERSION register

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- csr_wr_en  in  1  write strobe, single cycle per write
- csr_rd_en  in  1  read strobe
- csr_addr  in  ADDR_W  byte address; bits [1:0] are ignored
- csr_wdata  in  DATA_W  write data
- csr_rdata  out  DATA_W  read data, registered
- csr_rvalid  out  1  read data valid, one cycle
- ch_busy  in  NUM_CH  channel is mid-operation; blocks commit
- snapshot_done  in  NUM_CH  per-channel done level
- stream_enable  out  NUM_CH  per-channel stream enable
- snap_len  out  NUM_CH*DATA_W  active snap length; channel c occupies [c*DATA_W +: DATA_W]
- align_lock_n  out  NUM_CH*8  active lock count per channel
- align_deassert_on_err  out  NUM_CH  active deassert-on-error flag per channel
- irq  out  1  level interrupt, registered

Behaviour:
- Global address map:
  - 0x00 CTRL: [0] global_en (RW); [1] commit (write 1 to request; reads as commit_pending).
  - 0x04 STATUS: [NUM_CH-1:0] sticky done, write-1-to-clear (W1C).
  - 0x08 IRQ_EN: [NUM_CH-1:0] RW.
  - 0x0C VERSION: read-only.
- Channel c registers, base 0x10 + 0x10*c:
  - +0x0 SNAP_LEN shadow, RW.
  - +0x4 ALIGN_CFG shadow: [7:0] lock_n, [8] deassert_on_err, RW.
  - +0x8 CH_EN: [0], RW, not shadowed.
  - +0xC: reserved.
- Unmapped, reserved or out-of-range addresses: writes are ignored; reads return 0 with csr_rvalid still asserted.
- Reset values:
  - global_en=0, commit_pending=0, STATUS=0, IRQ_EN=0, CH_EN=0.
  - Shadow and active SNAP_LEN = 0.
  - Shadow and active lock_n = LOCK_N_DEF; deassert_on_err = 1.
  - csr_rdata=0, csr_rvalid=0, irq=0.
- Writes take effect on the clock edge where csr_wr_en=1.
- Reads:
  - csr_rd_en sampled at edge N gives csr_rdata and csr_rvalid=1 after edge N+1.
  - Otherwise csr_rvalid=0 and csr_rdata holds its last value.
  - Back-to-back reads are allowed, one per cycle.
  - A read and a write to the same address in the same cycle return the pre-write value.
- stream_enable[c] = global_en & CH_EN[c], combinational from the registers, so it changes the cycle after the write.
- Commit:
  - Writing CTRL with [1]=1 sets commit_pending.
  - On any edge where commit_pending=1 and ch_busy == 0, all channels' active registers load from shadow and commit_pending clears.
  - A committed lock_n of 0 loads as LOCK_N_DEF.
  - If ch_busy is nonzero, commit_pending stays set indefinitely; there is no timeout.
  - A second commit request while pending has no further effect.
  - Shadow writes made while a commit is pending are included in the eventual commit.
  - Shadow read-back returns the raw written value, including 0 for lock_n.
- Done capture:
  - snapshot_done is registered once.
  - A rising edge on channel c sets STATUS[c] on the following edge.
  - A level held high sets the bit only once, at the rising edge.
  - W1C writes clear the selected bits; if a set event and a clear land in the same cycle, the set wins.
- irq is registered: irq <= |(STATUS & IRQ_EN), so it follows STATUS/IRQ_EN changes by one cycle.
- Asynchronous reset mid-operation (pending commit, outstanding read) immediately forces every register and output to its reset value. No partial commit and no stale rvalid may follow.

Test Plan:
- Reset, then read 0x0C, 0x10, 0x14 -> rvalid exactly 1 cycle after rd_en; data 0x0002_0000, 0x0, 0x110 (lock_n=16, deassert=1); all outputs at reset values.
- Write SNAP_LEN ch1=0x400 with no commit -> snap_len ch1 stays 0. Write CTRL=0x2 with ch_busy=0 -> ch1 snap_len=0x400 one cycle later; CTRL reads bit1=0.
- Hold ch_busy=4'b0010 and write CTRL=0x2 -> pending reads 1 for 20 cycles and outputs do not change. Drop ch_busy -> commit occurs on the next edge.
- Write ALIGN_CFG ch2=0x000 and commit -> align_lock_n ch2=16, deassert=0; readback of ch2 ALIGN_CFG returns 0x000.
- Set IRQ_EN=0x1 and pulse snapshot_done[0] -> STATUS=0x1, irq=1. Write STATUS=0x1 in the same cycle as a new rising edge on done[0] -> STATUS stays 1. Write STATUS=0x1 alone -> STATUS=0 and irq=0 one cycle later.
- Set global_en=1 and CH_EN ch3=1 -> stream_enable=4'b1000. Assert rst mid-pending-commit -> stream_enable=0, pending=0, rvalid=0 immediately.
